morse_key_timer: RTL and testbench
==================================

Name: morse_key_timer

Overview:
Front-end sequencer for the morse decoder. It samples a raw straight-key input and measures press and gap durations in units of a timebase tick. It emits the single-cycle dot, dash, lg (letter gap) and wg (word gap) strobes that step the decoder state machine. It also flags presses that are too long.

Parameters:
CNT_W, 8, width of the duration counter; the counter saturates at 2^CNT_W-1.
MIN_PRESS, 1, presses shorter than this many ticks are glitches and are discarded.
DOT_MAX, 2, presses of MIN_PRESS..DOT_MAX ticks are a dot.
DASH_MAX, 6, presses of DOT_MAX+1..DASH_MAX ticks are a dash; longer presses are an error.
LG_MIN, 3, key-up ticks after a symbol before lg fires.
WG_MIN, 7, key-up ticks after a symbol before wg fires.
Legal values: 1<=MIN_PRESS<=DOT_MAX<DASH_MAX; LG_MIN<WG_MIN; all values < 2^CNT_W. These are checked by elaboration-time assertion.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
key_in  in  1  raw key, asynchronous to clk; 1 = pressed.
tick  in  1  timebase enable; one unit is one clk cycle with tick=1.
dot  out  1  one-cycle strobe: dot symbol.
dash  out  1  one-cycle strobe: dash symbol.
lg  out  1  one-cycle strobe: letter complete.
wg  out  1  one-cycle strobe: word complete.
err  out  1  one-cycle strobe: press longer than DASH_MAX.
busy  out  1  high whenever state != IDLE.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset (async, any time, including mid-press or mid-gap):
  - state=IDLE; counter=0; both sync flops=0; letter_open=0; from_idle=0.
  - All outputs 0; no strobe is emitted on reset release.
- key_in passes through a 2-flop synchroniser to give key_s. All decisions use key_s only.
- All outputs are registered. Strobes are exactly one clk cycle wide. At most one of dot/dash/err is high in any cycle.
- Counter:
  - On entry to PRESS or GAP, load tick?1:0.
  - In that state, add 1 on each edge with tick=1.
  - Saturate at the maximum; never wrap.
- IDLE:
  - key_s=1: go to PRESS, set from_idle=1.
  - Otherwise stay; busy=0.
- PRESS (key_s=1): count ticks.
- PRESS, on the edge where key_s=0 is sampled, let d = counter value and classify:
  - d<MIN_PRESS: glitch, no strobe. If from_idle, go to IDLE. Otherwise go to GAP with the counter restarted; letter_open is unchanged.
  - MIN_PRESS<=d<=DOT_MAX: dot=1 next cycle; letter_open=1; go to GAP.
  - DOT_MAX<d<=DASH_MAX: dash=1 next cycle; letter_open=1; go to GAP.
  - d>DASH_MAX: err=1 next cycle; letter_open=1; go to GAP. lg still fires later so the decoder clears.
- Timing, tick tied high: key_in high for N cycles gives d=N. The strobe is high in the 3rd cycle after key_in falls.
- GAP (key_s=0): count ticks.
  - When the counter reaches LG_MIN with letter_open=1: lg=1 for one cycle, then letter_open=0.
  - When the counter reaches WG_MIN: wg=1 for one cycle, go to IDLE.
  - lg and wg never share a cycle.
- GAP, key_s=1 sampled before WG_MIN: go to PRESS, set from_idle=0, no gap strobe.
  - If LG_MIN was already reached, lg has been sent and the new symbol starts a new letter.
  - Otherwise the new symbol continues the current letter.
- Saturation: a long press still classifies as err; no wrap to a short count.
- tick=0 throughout freezes all counting. States change only on key_s edges, apart from glitch and reset handling.

Test Plan:
- Defaults, tick=1; key_in high 2 cycles, then low 20 cycles -> dot once, lg 3 ticks after gap start, wg 7 ticks after gap start, busy back to 0; no err.
- Defaults, tick=1; high 5, low 2, high 1, low 20 -> dash, then dot; exactly one lg and one wg; no lg between the two symbols.
- Defaults, tick=1; high 10 -> err strobe only, no dot/dash; lg and wg follow in the gap.
- tick=1 every 4th cycle, defaults; key_in high 8 cycles (2 ticks) -> dot; high 16 cycles (4 ticks) -> dash.
- MIN_PRESS=2; from IDLE, 1-tick pulse -> no strobes, busy returns to 0. 1-tick pulse in a gap 2 ticks after a dot -> gap restarts; lg arrives 3 ticks after the glitch release.
- rst asserted mid-PRESS (after 3 ticks) and released 2 cycles later with key_in low -> all outputs 0 immediately; no strobes afterwards; busy=0.

Source files
------------

// File: rtl/morse_key_timer.sv
// Straight-key front end: synchronises the key, times presses and gaps in tick
// units, and emits registered dot/dash/err/lg/wg strobes for the morse decoder.
module morse_key_timer #(
    parameter int CNT_W     = 8,
    parameter int MIN_PRESS = 1,
    parameter int DOT_MAX   = 2,
    parameter int DASH_MAX  = 6,
    parameter int LG_MIN    = 3,
    parameter int WG_MIN    = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    input  logic tick,
    output logic dot,
    output logic dash,
    output logic lg,
    output logic wg,
    output logic err,
    output logic busy
);

    localparam int LIMIT = 1 << CNT_W;

    if (!(MIN_PRESS >= 1 && MIN_PRESS <= DOT_MAX && DOT_MAX < DASH_MAX &&
          LG_MIN < WG_MIN && DASH_MAX < LIMIT && WG_MIN < LIMIT)) begin : g_bad_params
        $error("morse_key_timer: illegal timing parameter set");
    end

    localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_PRESS);
    localparam logic [CNT_W-1:0] DOT_C  = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] DASH_C = CNT_W'(DASH_MAX);
    localparam logic [CNT_W-1:0] LG_C   = CNT_W'(LG_MIN);
    localparam logic [CNT_W-1:0] WG_C   = CNT_W'(WG_MIN);
    localparam logic [CNT_W-1:0] MAX_C  = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sync1_q;
    logic             key_s_q;
    logic             letter_open_q;
    logic             from_idle_q;
    logic             dot_q, dash_q, lg_q, wg_q, err_q, busy_q;

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_load;

    // Saturating increment on tick; the entry value already counts the entry tick.
    always_comb begin
        cnt_d    = (tick && cnt_q != MAX_C) ? cnt_q + 1'b1 : cnt_q;
        cnt_load = tick ? CNT_W'(1) : '0;
    end

    // NOTE: every register here, including the synchroniser, uses non-blocking
    // assignment so all flops update from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            sync1_q       <= 1'b0;
            key_s_q       <= 1'b0;
            letter_open_q <= 1'b0;
            from_idle_q   <= 1'b0;
            dot_q         <= 1'b0;
            dash_q        <= 1'b0;
            lg_q          <= 1'b0;
            wg_q          <= 1'b0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            sync1_q <= key_in;
            key_s_q <= sync1_q;
            dot_q   <= 1'b0;
            dash_q  <= 1'b0;
            lg_q    <= 1'b0;
            wg_q    <= 1'b0;
            err_q   <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (key_s_q) begin
                        state_q     <= PRESS;
                        cnt_q       <= cnt_load;
                        from_idle_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end

                PRESS: begin
                    if (key_s_q) begin
                        cnt_q <= cnt_d;
                    end else if (cnt_q < MIN_C) begin
                        if (from_idle_q) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= GAP;
                            cnt_q   <= cnt_load;
                        end
                    end else begin
                        state_q       <= GAP;
                        cnt_q         <= cnt_load;
                        letter_open_q <= 1'b1;
                        if (cnt_q <= DOT_C)       dot_q  <= 1'b1;
                        else if (cnt_q <= DASH_C) dash_q <= 1'b1;
                        else                      err_q  <= 1'b1;
                    end
                end

                GAP: begin
                    if (key_s_q) begin
                        state_q     <= PRESS;
                        cnt_q       <= cnt_load;
                        from_idle_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                        // lg takes priority so it can never share a cycle with wg.
                        if (letter_open_q && cnt_d >= LG_C) begin
                            lg_q          <= 1'b1;
                            letter_open_q <= 1'b0;
                        end else if (cnt_d >= WG_C) begin
                            wg_q    <= 1'b1;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dot  = dot_q;
    assign dash = dash_q;
    assign lg   = lg_q;
    assign wg   = wg_q;
    assign err  = err_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_morse_key_timer.sv
// Bench for morse_key_timer: default and MIN_PRESS=2 instances driven together,
// compared every cycle against a duration-based reference model.
module tb_morse_key_timer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_in = 1'b0;
    logic tick = 1'b0;

    logic dot1, dash1, lg1, wg1, err1, busy1;
    logic dot2, dash2, lg2, wg2, err2, busy2;

    int checks = 0;
    int errors = 0;
    int ph = 0;
    int c1[5];
    int c2[5];

    always #5 clk = ~clk;

    morse_key_timer u_dut1 (
        .clk(clk), .rst(rst), .key_in(key_in), .tick(tick),
        .dot(dot1), .dash(dash1), .lg(lg1), .wg(wg1), .err(err1), .busy(busy1)
    );

    morse_key_timer #(.MIN_PRESS(2)) u_dut2 (
        .clk(clk), .rst(rst), .key_in(key_in), .tick(tick),
        .dot(dot2), .dash(dash2), .lg(lg2), .wg(wg2), .err(err2), .busy(busy2)
    );

    wire [5:0] o1 = {busy1, err1, wg1, lg1, dash1, dot1};
    wire [5:0] o2 = {busy2, err2, wg2, lg2, dash2, dot2};

    // Reference: key seen two samples late; press and gap lengths in ticks.
    typedef struct {
        bit       s1, s2;
        bit       active, pressing, open, from_idle;
        int       ticks;
        bit [5:0] out;   // {busy, err, wg, lg, dash, dot}
    } mdl_t;

    mdl_t m1, m2;

    function automatic mdl_t mreset();
        mdl_t m;
        m.s1 = 0; m.s2 = 0; m.active = 0; m.pressing = 0; m.open = 0;
        m.from_idle = 0; m.ticks = 0; m.out = '0;
        return m;
    endfunction

    function automatic mdl_t mstep(mdl_t m, bit k, bit t, int min_press);
        bit ks = m.s2;
        int n;
        m.s2 = m.s1;
        m.s1 = k;
        m.out[4:0] = '0;
        n = (m.ticks + t > 255) ? 255 : m.ticks + t;
        if (!m.active) begin
            if (ks) begin
                m.active = 1; m.pressing = 1; m.from_idle = 1; m.ticks = t;
            end
        end else if (m.pressing) begin
            if (ks) m.ticks = n;
            else begin
                if (m.ticks < min_press) begin
                    if (m.from_idle) m.active = 0;
                end else begin
                    m.open = 1;
                    if (m.ticks <= 2)      m.out[0] = 1;
                    else if (m.ticks <= 6) m.out[1] = 1;
                    else                   m.out[4] = 1;
                end
                m.pressing = 0;
                m.ticks = m.active ? t : 0;
            end
        end else begin
            if (ks) begin
                m.pressing = 1; m.from_idle = 0; m.ticks = t;
            end else begin
                m.ticks = n;
                if (m.open && m.ticks >= 3) begin
                    m.out[2] = 1; m.open = 0;
                end else if (m.ticks >= 7) begin
                    m.out[3] = 1; m.active = 0;
                end
            end
        end
        m.out[5] = m.active;
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_counts();
        for (int i = 0; i < 5; i++) begin
            c1[i] = 0;
            c2[i] = 0;
        end
    endtask

    // One clock: drive, let the edge happen, advance the model, compare at negedge.
    task automatic cyc(input bit k, input bit t);
        key_in = k;
        tick   = t;
        @(posedge clk);
        if (rst) begin
            m1 = mreset();
            m2 = mreset();
        end else begin
            m1 = mstep(m1, k, t, 1);
            m2 = mstep(m2, k, t, 2);
        end
        @(negedge clk);
        check($sformatf("dut1_out@%0t", $time), 32'(o1), 32'(m1.out));
        check($sformatf("dut2_out@%0t", $time), 32'(o2), 32'(m2.out));
        c1[0] += int'(dot1); c1[1] += int'(dash1); c1[2] += int'(lg1);
        c1[3] += int'(wg1);  c1[4] += int'(err1);
        c2[0] += int'(dot2); c2[1] += int'(dash2); c2[2] += int'(lg2);
        c2[3] += int'(wg2);  c2[4] += int'(err2);
    endtask

    task automatic run(input bit k, input int len, input int per);
        for (int i = 0; i < len; i++) begin
            cyc(k, (ph % per) == 0);
            ph++;
        end
    endtask

    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        m1 = mreset();
        m2 = mreset();
        #1;
        check("rst_immediate_dut1", 32'(o1), 32'd0);
        check("rst_immediate_dut2", 32'(o2), 32'd0);
        for (int i = 0; i < ncyc; i++) cyc(key_in, 1'b1);
        rst = 1'b0;
    endtask

    task automatic expect_counts(input string tag, input int dot_n, input int dash_n,
                                 input int lg_n, input int wg_n, input int err_n);
        check({tag, "_dot"},  32'(c1[0]), 32'(dot_n));
        check({tag, "_dash"}, 32'(c1[1]), 32'(dash_n));
        check({tag, "_lg"},   32'(c1[2]), 32'(lg_n));
        check({tag, "_wg"},   32'(c1[3]), 32'(wg_n));
        check({tag, "_err"},  32'(c1[4]), 32'(err_n));
    endtask

    initial begin
        bit k;
        int len;
        m1 = mreset();
        m2 = mreset();
        clr_counts();

        repeat (3) cyc(1'b0, 1'b1);
        check("reset_dut1", 32'(o1), 32'd0);
        check("reset_dut2", 32'(o2), 32'd0);
        rst = 1'b0;

        clr_counts();
        run(1, 2, 1); run(0, 20, 1);
        expect_counts("dot_only", 1, 0, 1, 1, 0);
        check("dot_only_busy", 32'(busy1), 32'd0);

        clr_counts();
        run(1, 5, 1); run(0, 2, 1); run(1, 1, 1); run(0, 20, 1);
        expect_counts("dash_dot", 1, 1, 1, 1, 0);

        clr_counts();
        run(1, 10, 1); run(0, 20, 1);
        expect_counts("long_press", 0, 0, 1, 1, 1);

        clr_counts();
        run(1, 300, 1); run(0, 20, 1);
        expect_counts("saturate", 0, 0, 1, 1, 1);

        clr_counts();
        ph = 0;
        run(1, 8, 4); run(0, 40, 4);
        run(1, 16, 4); run(0, 40, 4);
        expect_counts("slow_tick", 1, 1, 2, 2, 0);

        clr_counts();
        run(1, 1, 1); run(0, 10, 1);
        check("glitch_idle_strobes", 32'(c2[0] + c2[1] + c2[2] + c2[3] + c2[4]), 32'd0);
        check("glitch_idle_busy", 32'(busy2), 32'd0);

        clr_counts();
        run(1, 2, 1); run(0, 2, 1); run(1, 1, 1); run(0, 20, 1);
        check("glitch_gap_dot", 32'(c2[0]), 32'd1);
        check("glitch_gap_lg",  32'(c2[2]), 32'd1);
        check("glitch_gap_wg",  32'(c2[3]), 32'd1);

        clr_counts();
        run(1, 5, 1);
        key_in = 1'b0;
        do_reset(2);
        run(0, 20, 1);
        check("rst_midpress_strobes", 32'(c1[0] + c1[1] + c1[2] + c1[3] + c1[4]), 32'd0);
        check("rst_midpress_busy", 32'(busy1), 32'd0);

        k = 1'b0;
        for (int r = 0; r < 400; r++) begin
            k = ~k;
            len = (r % 9 == 0) ? int'($urandom_range(8, 30)) : int'($urandom_range(1, 9));
            for (int i = 0; i < len; i++) cyc(k, $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 59) == 0) do_reset(int'($urandom_range(1, 3)));
        end
        run(0, 60, 1);
        check("final_idle_dut1", 32'(busy1), 32'd0);
        check("final_idle_dut2", 32'(busy2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
